// File: rtl/hnoc_pkg.sv
// hnoc_pkg: shared definitions for the hierarchical NoC switch blocks.
//   NUM_REQ    - number of input streams competing for one output port
//   MAX_FLIT_W - widest flit the address helpers accept
//   flit_addr  - extracts the destination address (top addrWidth bits)
//   in_range   - inclusive unsigned range test; empty when lo > hi
package hnoc_pkg;

    localparam int NUM_REQ    = 3;
    localparam int MAX_FLIT_W = 256;

    function automatic logic [31:0] flit_addr(input logic [MAX_FLIT_W-1:0] flit,
                                              input int dataWidth,
                                              input int addrWidth);
        logic [31:0] mask;
        mask = (32'd1 << addrWidth) - 32'd1;
        return 32'(flit >> (dataWidth - addrWidth)) & mask;
    endfunction

    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/hnoc_port_arbiter_if.sv
// hnoc_port_arbiter_if: handshake bundle between three requesters, one
// output-port arbiter and the downstream consumer.
//   slave  - arbiter side (takes flits, drives readies and the output stage)
//   master - environment side (drives flits/valids and downstream ready)
interface hnoc_port_arbiter_if #(
    parameter int DataWidth = 36
);
    logic [DataWidth-1:0] i_data1;
    logic [DataWidth-1:0] i_data2;
    logic [DataWidth-1:0] i_data3;
    logic                 i_data_valid1;
    logic                 i_data_valid2;
    logic                 i_data_valid3;
    logic                 o_data_ready1;
    logic                 o_data_ready2;
    logic                 o_data_ready3;
    logic [DataWidth-1:0] o_data;
    logic                 o_data_valid;
    logic                 i_data_ready;
    logic [2:0]           o_grant;

    modport slave (
        input  i_data1, i_data2, i_data3,
        input  i_data_valid1, i_data_valid2, i_data_valid3,
        output o_data_ready1, o_data_ready2, o_data_ready3,
        output o_data, o_data_valid, o_grant,
        input  i_data_ready
    );

    modport master (
        output i_data1, i_data2, i_data3,
        output i_data_valid1, i_data_valid2, i_data_valid3,
        input  o_data_ready1, o_data_ready2, o_data_ready3,
        input  o_data, o_data_valid, o_grant,
        output i_data_ready
    );
endinterface

// File: rtl/rr_arbiter3.sv
// rr_arbiter3: three-way round-robin pick.
//   i_clk, i_reset - clock, async active-low reset (pointer -> 0)
//   req            - requests, already qualified by the caller
//   gnt            - one-hot winner, zero when nothing requests
// The search starts at ptr and wraps; after a grant ptr moves one past the
// winner, so a continuously requesting input waits at most two grants.
module rr_arbiter3
    import hnoc_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt
);

    logic [1:0] ptr;
    logic [1:0] winIdx;
    logic       found;
    logic [2:0] slot;

    always_comb begin
        gnt    = '0;
        winIdx = ptr;
        found  = 1'b0;
        slot   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            slot = 3'(ptr) + 3'(i);
            if (slot >= 3'd3) slot = slot - 3'd3;
            if (!found && req[slot[1:0]]) begin
                found  = 1'b1;
                winIdx = slot[1:0];
            end
        end
        if (found) gnt[winIdx] = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)   ptr <= 2'd0;
        else if (found) ptr <= (winIdx == 2'd2) ? 2'd0 : winIdx + 2'd1;
    end

endmodule

// File: rtl/hnoc_port_arbiter.sv
// hnoc_port_arbiter: shares one switch output port among three inputs.
//   i_clk, i_reset - clock, async active-low reset
//   bus (slave)    - three flit/valid/ready requesters, registered output
//                    flit with valid/ready, and o_grant (one-hot source of
//                    the held flit, zero when empty)
// A requester is eligible when valid and its destination address lies in
// [DestMin, DestMax]; out-of-range flits are left for the sibling port.
module hnoc_port_arbiter
    import hnoc_pkg::*;
#(
    parameter int DataWidth = 36,
    parameter int AddrWidth = 4,
    parameter int DestMin   = 0,
    parameter int DestMax   = 1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    hnoc_port_arbiter_if.slave  bus
);

    logic [NUM_REQ-1:0][DataWidth-1:0] flits;
    logic [NUM_REQ-1:0] valids;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [DataWidth-1:0] winFlit;
    logic [DataWidth-1:0] dataQ;
    logic                 validQ;
    logic [NUM_REQ-1:0]   grantQ;
    logic                 loadOk;

    assign flits  = {bus.i_data3, bus.i_data2, bus.i_data1};
    assign valids = {bus.i_data_valid3, bus.i_data_valid2, bus.i_data_valid1};

    always_comb begin
        eligible = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            eligible[k] = valids[k] &&
                in_range(flit_addr(MAX_FLIT_W'(flits[k]), DataWidth, AddrWidth),
                         32'(DestMin), 32'(DestMax));
        end
    end

    // Empty, or full and draining this cycle. Gating with reset keeps every
    // ready low while reset is held, so no handshake completes then.
    assign loadOk = !validQ || bus.i_data_ready;
    assign req    = eligible & {NUM_REQ{loadOk && i_reset}};

    rr_arbiter3 u_rr (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .req     (req),
        .gnt     (gnt)
    );

    always_comb begin
        winFlit = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt[k]) winFlit = flits[k];
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            dataQ  <= '0;
            validQ <= 1'b0;
            grantQ <= '0;
        end else if (|gnt) begin
            dataQ  <= winFlit;
            validQ <= 1'b1;
            grantQ <= gnt;
        end else if (validQ && bus.i_data_ready) begin
            validQ <= 1'b0;
            grantQ <= '0;
        end
    end

    assign bus.o_data_ready1 = gnt[0];
    assign bus.o_data_ready2 = gnt[1];
    assign bus.o_data_ready3 = gnt[2];
    assign bus.o_data        = dataQ;
    assign bus.o_data_valid  = validQ;
    assign bus.o_grant       = grantQ;

endmodule

// File: tb/tb_hnoc_port_arbiter.sv
// Scoreboard bench for hnoc_port_arbiter: the driver computes expected
// winners from the arbitration rules and queues expected output flits; a
// monitor on the falling edge compares whatever the DUT presents.
module tb_hnoc_port_arbiter;

    localparam int DW   = 36;
    localparam int AW   = 4;
    localparam int DMIN = 0;
    localparam int DMAX = 1;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [2:0]    grant;
    } exp_t;

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    hnoc_port_arbiter_if #(.DataWidth(DW)) bus ();

    hnoc_port_arbiter #(
        .DataWidth(DW), .AddrWidth(AW), .DestMin(DMIN), .DestMax(DMAX)
    ) dut (
        .i_clk   (clk),
        .i_reset (rstN),
        .bus     (bus)
    );

    exp_t sbq[$];
    int   winLog[$];
    int   nChecks = 0;
    int   nFails  = 0;
    int   mPtr    = 0;
    bit   mFull   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mkFlit(input int addr, input logic [31:0] payload);
        logic [DW-1:0] f;
        f = {4'(addr), payload};
        return f;
    endfunction

    // Monitor: the held flit must match the queue head every cycle it is
    // shown; it retires only when downstream accepts it.
    initial begin
        forever begin
            @(negedge clk);
            if (rstN && bus.o_data_valid) begin
                if (sbq.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("FAIL unexpected_flit: got %0h expected none", bus.o_data);
                end else begin
                    check("out_data", bus.o_data, sbq[0].data);
                    check("out_grant", bus.o_grant, sbq[0].grant);
                    if (bus.i_data_ready) void'(sbq.pop_front());
                end
            end
        end
    end

    // One cycle of stimulus: drive after the edge, then check readies and
    // predict what the next edge should load.
    task automatic step(input logic rst, input logic [2:0] v,
                        input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                        input logic [DW-1:0] d3, input logic rdy);
        logic [DW-1:0] f[3];
        logic [2:0]    expR;
        bit            loadOk;
        int            w;
        int            k;
        int            a;
        @(posedge clk);
        #1;
        rstN = rst;
        bus.i_data1 = d1; bus.i_data2 = d2; bus.i_data3 = d3;
        bus.i_data_valid1 = v[0]; bus.i_data_valid2 = v[1]; bus.i_data_valid3 = v[2];
        bus.i_data_ready = rdy;
        if (!rst) begin
            mFull = 1'b0;
            mPtr  = 0;
            sbq.delete();
        end
        #1;
        f[0] = d1; f[1] = d2; f[2] = d3;
        expR = 3'b000;
        check("out_valid", bus.o_data_valid, mFull);
        if (!mFull) check("grant_empty", bus.o_grant, 3'b000);
        if (!rst) check("data_in_reset", bus.o_data, '0);
        if (rst) begin
            loadOk = !mFull || rdy;
            w = -1;
            if (loadOk) begin
                for (int off = 0; off < 3; off++) begin
                    k = (mPtr + off) % 3;
                    a = int'(f[k][DW-1 -: AW]);
                    if (w < 0 && v[k] && a >= DMIN && a <= DMAX) w = k;
                end
            end
            if (w >= 0) begin
                expR[w] = 1'b1;
                sbq.push_back('{data: f[w], grant: 3'(1 << w)});
                winLog.push_back(w + 1);
                mFull = 1'b1;
                mPtr  = (w + 1) % 3;
            end else if (mFull && rdy) begin
                mFull = 1'b0;
            end
        end
        check("readies", {bus.o_data_ready3, bus.o_data_ready2, bus.o_data_ready1}, expR);
    endtask

    initial begin
        logic [DW-1:0] fa, fb, fc, z;
        int            expSeq[6];
        z = '0;
        bus.i_data1 = '0; bus.i_data2 = '0; bus.i_data3 = '0;
        bus.i_data_valid1 = 1'b0; bus.i_data_valid2 = 1'b0; bus.i_data_valid3 = 1'b0;
        bus.i_data_ready = 1'b1;

        // Reset held with everyone requesting: nothing may be accepted.
        fa = mkFlit(0, 32'h11);
        repeat (3) step(1'b0, 3'b111, fa, fa, fa, 1'b1);

        // Release with only input 2 valid.
        step(1'b1, 3'b010, z, 36'h0_0000_00A5, z, 1'b1);
        check("release_ready2", bus.o_data_ready2, 1'b1);

        // Drain it with nothing behind; pointer must sit at input 3.
        step(1'b1, 3'b000, z, z, z, 1'b1);
        step(1'b1, 3'b000, z, z, z, 1'b1);
        check("empty_valid", bus.o_data_valid, 1'b0);
        step(1'b1, 3'b111, mkFlit(0, 32'h21), mkFlit(1, 32'h22), mkFlit(1, 32'h23), 1'b1);
        check("ptr_after_empty", bus.o_data_ready3, 1'b1);

        // Round robin from pointer 0.
        winLog.delete();
        for (int i = 0; i < 6; i++)
            step(1'b1, 3'b111, mkFlit(1, 32'h100 + i), mkFlit(1, 32'h200 + i),
                 mkFlit(1, 32'h300 + i), 1'b1);
        expSeq = '{1, 2, 3, 1, 2, 3};
        for (int i = 0; i < 6; i++)
            check("rr_order", (i < winLog.size()) ? winLog[i] : -1, expSeq[i]);

        // Address filter: input 1 out of range, never ready.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 3'b101, mkFlit(2, 32'h400 + i), z, mkFlit(0, 32'h500 + i), 1'b1);
            check("filter_ready1", bus.o_data_ready1, 1'b0);
        end

        // Backpressure then drain-and-refill.
        step(1'b1, 3'b111, mkFlit(0, 32'h601), mkFlit(0, 32'h602), mkFlit(0, 32'h603), 1'b1);
        repeat (5) step(1'b1, 3'b111, mkFlit(0, 32'h611), mkFlit(0, 32'h612),
                        mkFlit(0, 32'h613), 1'b0);
        step(1'b1, 3'b111, mkFlit(0, 32'h621), mkFlit(0, 32'h622), mkFlit(0, 32'h623), 1'b1);

        // Reset while full and stalled; input 1 must win first afterwards.
        step(1'b1, 3'b111, mkFlit(1, 32'h701), mkFlit(1, 32'h702), mkFlit(1, 32'h703), 1'b0);
        step(1'b0, 3'b111, mkFlit(1, 32'h711), mkFlit(1, 32'h712), mkFlit(1, 32'h713), 1'b0);
        check("reset_async_valid", bus.o_data_valid, 1'b0);
        step(1'b1, 3'b111, mkFlit(1, 32'h721), mkFlit(1, 32'h722), mkFlit(1, 32'h723), 1'b1);
        check("post_reset_first", bus.o_data_ready1, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            fa = mkFlit($urandom_range(0, 3), $urandom);
            fb = mkFlit($urandom_range(0, 3), $urandom);
            fc = mkFlit($urandom_range(0, 3), $urandom);
            step(($urandom_range(0, 99) != 0), 3'($urandom), fa, fb, fc,
                 ($urandom_range(0, 3) != 0));
        end

        // Flush and confirm every expected flit was seen.
        repeat (3) step(1'b1, 3'b000, z, z, z, 1'b1);
        @(negedge clk);
        #1;
        check("scoreboard_empty", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
